mc_ctrl: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB states and drives the datapath control strobes state by state. Memory steps wait on a memory-ready handshake. The block sits between the instruction register (IR) and the shared-memory multi-cycle datapath. It adds J support and reports illegal opcodes.

---
 rtl/mc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB and drives
// registered datapath strobes, decoded from the state being entered.
module mc_ctrl #(
  parameter int ALUCTRL_W = 5,
  parameter int EXTOP_W   = 2,
  parameter int MEM_WAIT  = 1,
  parameter int EN_JUMP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic [1:0]           Branch,
  output logic                 jump,
  output logic                 IRWrite,
  output logic                 MemR,
  output logic                 MemW,
  output logic                 IorD,
  output logic                 RegW,
  output logic                 RegDst,
  output logic                 Mem2R,
  output logic                 Alusrc,
  output logic [EXTOP_W-1:0]   EXTOp,
  output logic [ALUCTRL_W-1:0] Aluctrl,
  output logic                 illegal,
  output logic [3:0]           state
);

  localparam logic [ALUCTRL_W-1:0] ALUOp_NOP  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALUOp_ADDU = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALUOp_ADD  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALUOp_SUBU = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALUOp_SUB  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALUOp_OR   = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALUOp_SLT  = ALUCTRL_W'(9);

  localparam logic [EXTOP_W-1:0] EXT_ZERO    = EXTOP_W'(0);
  localparam logic [EXTOP_W-1:0] EXT_SIGNED  = EXTOP_W'(1);
  localparam logic [EXTOP_W-1:0] EXT_HIGHPOS = EXTOP_W'(2);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXE_R  = 4'd3,
    S_WB_R   = 4'd4,
    S_EXE_I  = 4'd5,
    S_WB_I   = 4'd6,
    S_MEMADR = 4'd7,
    S_MEMRD  = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEMWR  = 4'd10,
    S_BR     = 4'd11,
    S_JMP    = 4'd12
  } state_t;

  state_t                 state_q, next_state;
  logic [5:0]             op_q, fn_q, op_eff, fn_eff;
  logic                   mem_ok, bad_state;
  logic                   pcwrite_q, irwrite_q;
  logic                   nx_pcw, nx_jump, nx_irw, nx_memr, nx_memw, nx_iord;
  logic                   nx_regw, nx_regdst, nx_m2r, nx_asrc, nx_illegal;
  logic [1:0]             nx_branch;
  logic [EXTOP_W-1:0]     nx_ext;
  logic [ALUCTRL_W-1:0]   nx_alu;

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t ns;
    ns = S_FETCH;
    case (op)
      OP_RTYPE: if (fn inside {F_ADDU, F_ADD, F_SUBU, F_SUB, F_SLT}) ns = S_EXE_R;
      OP_ORI, OP_SLTI, OP_LUI: ns = S_EXE_I;
      OP_LW, OP_SW:            ns = S_MEMADR;
      OP_BEQ, OP_BNE:          ns = S_BR;
      OP_J:                    if (EN_JUMP != 0) ns = S_JMP;
      default:                 ns = S_FETCH;
    endcase
    return ns;
  endfunction

  function automatic logic [ALUCTRL_W-1:0] alu_r(input logic [5:0] fn);
    logic [ALUCTRL_W-1:0] a;
    case (fn)
      F_ADDU:  a = ALUOp_ADDU;
      F_ADD:   a = ALUOp_ADD;
      F_SUBU:  a = ALUOp_SUBU;
      F_SUB:   a = ALUOp_SUB;
      F_SLT:   a = ALUOp_SLT;
      default: a = ALUOp_NOP;
    endcase
    return a;
  endfunction

  function automatic logic [ALUCTRL_W-1:0] alu_i(input logic [5:0] op);
    logic [ALUCTRL_W-1:0] a;
    case (op)
      OP_ORI, OP_LUI: a = ALUOp_OR;
      OP_SLTI:        a = ALUOp_SLT;
      default:        a = ALUOp_NOP;
    endcase
    return a;
  endfunction

  function automatic logic [EXTOP_W-1:0] ext_i(input logic [5:0] op);
    logic [EXTOP_W-1:0] e;
    case (op)
      OP_SLTI: e = EXT_SIGNED;
      OP_LUI:  e = EXT_HIGHPOS;
      default: e = EXT_ZERO;
    endcase
    return e;
  endfunction

  assign mem_ok = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  // In DECODE the IR fields are consumed live; afterwards only the latched copy matters.
  assign op_eff = (state_q == S_DECODE) ? OpCode : op_q;
  assign fn_eff = (state_q == S_DECODE) ? Funct  : fn_q;

  always_comb begin
    next_state = S_FETCH;
    bad_state  = 1'b0;
    case (state_q)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: next_state = decode_next(OpCode, Funct);
      S_EXE_R:  next_state = S_WB_R;
      S_WB_R:   next_state = S_FETCH;
      S_EXE_I:  next_state = S_WB_I;
      S_WB_I:   next_state = S_FETCH;
      S_MEMADR: next_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ok ? S_WB_MEM : S_MEMRD;
      S_WB_MEM: next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ok ? S_FETCH : S_MEMWR;
      S_BR:     next_state = S_FETCH;
      S_JMP:    next_state = S_FETCH;
      default: begin
        next_state = S_FETCH;
        bad_state  = 1'b1;
      end
    endcase
  end

  always_comb begin
    nx_pcw    = 1'b0;
    nx_branch = 2'b00;
    nx_jump   = 1'b0;
    nx_irw    = 1'b0;
    nx_memr   = 1'b0;
    nx_memw   = 1'b0;
    nx_iord   = 1'b0;
    nx_regw   = 1'b0;
    nx_regdst = 1'b0;
    nx_m2r    = 1'b0;
    nx_asrc   = 1'b0;
    nx_ext    = EXT_ZERO;
    nx_alu    = ALUOp_NOP;
    case (next_state)
      S_FETCH: begin
        nx_memr = 1'b1;
        nx_irw  = 1'b1;
        nx_pcw  = 1'b1;
        nx_alu  = ALUOp_ADDU;
      end
      S_DECODE: begin
        nx_alu = ALUOp_ADD;
        nx_ext = EXT_SIGNED;
      end
      S_EXE_R: nx_alu = alu_r(fn_eff);
      S_WB_R: begin
        nx_regw = 1'b1;
        nx_alu  = alu_r(fn_eff);
      end
      S_EXE_I: begin
        nx_asrc = 1'b1;
        nx_alu  = alu_i(op_eff);
        nx_ext  = ext_i(op_eff);
      end
      S_WB_I: begin
        nx_regw   = 1'b1;
        nx_regdst = 1'b1;
        nx_alu    = alu_i(op_eff);
        nx_ext    = ext_i(op_eff);
      end
      S_MEMADR: begin
        nx_asrc = 1'b1;
        nx_ext  = EXT_SIGNED;
        nx_alu  = ALUOp_ADD;
      end
      S_MEMRD: begin
        nx_memr = 1'b1;
        nx_iord = 1'b1;
      end
      S_WB_MEM: begin
        nx_regw   = 1'b1;
        nx_regdst = 1'b1;
        nx_m2r    = 1'b1;
      end
      S_MEMWR: begin
        nx_memw = 1'b1;
        nx_iord = 1'b1;
      end
      S_BR: begin
        nx_alu    = ALUOp_SUB;
        nx_branch = (op_eff == OP_BNE) ? 2'b10 : 2'b01;
      end
      S_JMP: begin
        nx_jump = 1'b1;
        nx_pcw  = 1'b1;
      end
      default: ;
    endcase
    nx_illegal = bad_state || ((state_q == S_DECODE) && (next_state == S_FETCH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      fn_q      <= '0;
      pcwrite_q <= 1'b0;
      irwrite_q <= 1'b0;
      Branch    <= 2'b00;
      jump      <= 1'b0;
      MemR      <= 1'b0;
      MemW      <= 1'b0;
      IorD      <= 1'b0;
      RegW      <= 1'b0;
      RegDst    <= 1'b0;
      Mem2R     <= 1'b0;
      Alusrc    <= 1'b0;
      EXTOp     <= EXT_ZERO;
      Aluctrl   <= ALUOp_NOP;
      illegal   <= 1'b0;
    end else begin
      state_q   <= next_state;
      if (state_q == S_DECODE) begin
        op_q <= OpCode;
        fn_q <= Funct;
      end
      pcwrite_q <= nx_pcw;
      irwrite_q <= nx_irw;
      Branch    <= nx_branch;
      jump      <= nx_jump;
      MemR      <= nx_memr;
      MemW      <= nx_memw;
      IorD      <= nx_iord;
      RegW      <= nx_regw;
      RegDst    <= nx_regdst;
      Mem2R     <= nx_m2r;
      Alusrc    <= nx_asrc;
      EXTOp     <= nx_ext;
      Aluctrl   <= nx_alu;
      illegal   <= nx_illegal;
    end
  end

  // A stalled fetch must not commit IR or PC until memory delivers the word.
  assign IRWrite = irwrite_q & mem_ok;
  assign PCWrite = pcwrite_q & (mem_ok | (state_q != S_FETCH));
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-cycle strobe vectors from an instruction-level model.
module tb_mc_ctrl;

  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_ADD  = 5'd2;
  localparam logic [4:0] ALUOp_SUBU = 5'd3;
  localparam logic [4:0] ALUOp_SUB  = 5'd4;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd9;
  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_ILL = 6;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] br;
    logic       jmp, irw, memr, memw, iord, regw, rdst, m2r, asrc;
    logic [1:0] ext;
    logic [4:0] alu;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0, rst_n = 1'b0, rst_nj = 1'b0, mem_ready = 1'b0;
  logic [5:0] OpCode = '0, Funct = '0;

  logic       pcw_m, jmp_m, irw_m, mr_m, mw_m, iord_m, rw_m, rd_m, m2r_m, as_m, ill_m;
  logic [1:0] br_m, ext_m;
  logic [4:0] alu_m;
  logic [3:0] st_m;
  logic       pcw_n, jmp_n, irw_n, mr_n, mw_n, iord_n, rw_n, rd_n, m2r_n, as_n, ill_n;
  logic [1:0] br_n, ext_n;
  logic [4:0] alu_n;
  logic [3:0] st_n;

  int n_chk = 0, n_err = 0;
  logic pend_ill = 1'b0;

  always #5 clk = ~clk;

  mc_ctrl #(.ALUCTRL_W(5), .EXTOP_W(2), .MEM_WAIT(1), .EN_JUMP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(pcw_m), .Branch(br_m), .jump(jmp_m), .IRWrite(irw_m), .MemR(mr_m),
    .MemW(mw_m), .IorD(iord_m), .RegW(rw_m), .RegDst(rd_m), .Mem2R(m2r_m),
    .Alusrc(as_m), .EXTOp(ext_m), .Aluctrl(alu_m), .illegal(ill_m), .state(st_m)
  );

  mc_ctrl #(.ALUCTRL_W(5), .EXTOP_W(2), .MEM_WAIT(1), .EN_JUMP(0)) u_nj (
    .clk(clk), .rst_n(rst_nj), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(pcw_n), .Branch(br_n), .jump(jmp_n), .IRWrite(irw_n), .MemR(mr_n),
    .MemW(mw_n), .IorD(iord_n), .RegW(rw_n), .RegDst(rd_n), .Mem2R(m2r_n),
    .Alusrc(as_n), .EXTOp(ext_n), .Aluctrl(alu_n), .illegal(ill_n), .state(st_n)
  );

  wire [23:0] obs_m = {st_m, pcw_m, br_m, jmp_m, irw_m, mr_m, mw_m, iord_m, rw_m,
                       rd_m, m2r_m, as_m, ext_m, alu_m, ill_m};
  wire [23:0] obs_n = {st_n, pcw_n, br_n, jmp_n, irw_n, mr_n, mw_n, iord_n, rw_n,
                       rd_n, m2r_n, as_n, ext_n, alu_n, ill_n};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input bit enj);
    case (op)
      6'b000000: return (fn inside {6'b100001, 6'b100000, 6'b100011, 6'b100010, 6'b101010}) ? C_R : C_ILL;
      6'b001101, 6'b001010, 6'b001111: return C_I;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010: return enj ? C_J : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'b100001: return ALUOp_ADDU;
      6'b100000: return ALUOp_ADD;
      6'b100011: return ALUOp_SUBU;
      6'b100010: return ALUOp_SUB;
      6'b101010: return ALUOp_SLT;
      default:   return ALUOp_NOP;
    endcase
  endfunction

  // One clock of stimulus; strobes are compared in the second half of the cycle.
  task automatic cyc(input ctl_t e, input logic mr, input logic [5:0] op,
                     input logic [5:0] fn, input string tag, input bit nj);
    @(negedge clk);
    mem_ready = mr;
    OpCode    = op;
    Funct     = fn;
    #1;
    if (nj) check(tag, {8'h0, obs_n}, {8'h0, e});
    else    check(tag, {8'h0, obs_m}, {8'h0, e});
  endtask

  function automatic ctl_t fetch_vec(input logic mr, input logic ill);
    ctl_t e;
    e = blank(4'd1);
    e.memr = 1'b1;
    e.alu  = ALUOp_ADDU;
    e.irw  = mr;
    e.pcw  = mr;
    e.ill  = ill;
    return e;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
    ctl_t e;
    int   cls;
    logic mr;
    for (int i = 0; i <= wf; i++) begin
      mr = (i == wf);
      cyc(fetch_vec(mr, (i == 0) ? pend_ill : 1'b0), mr, 6'($urandom), 6'($urandom), "fetch", 1'b0);
    end
    pend_ill = 1'b0;
    e = blank(4'd2);
    e.alu = ALUOp_ADD;
    e.ext = EXT_SIGNED;
    cyc(e, 1'($urandom), op, fn, "decode", 1'b0);
    cls = classify(op, fn, 1'b1);
    case (cls)
      C_R: begin
        e = blank(4'd3);
        e.alu = alu_of_funct(fn);
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "exe_r", 1'b0);
        e = blank(4'd4);
        e.regw = 1'b1;
        e.alu  = alu_of_funct(fn);
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "wb_r", 1'b0);
      end
      C_I: begin
        e = blank(4'd5);
        e.asrc = 1'b1;
        e.alu  = (op == 6'b001010) ? ALUOp_SLT : ALUOp_OR;
        e.ext  = (op == 6'b001101) ? EXT_ZERO : (op == 6'b001010) ? EXT_SIGNED : EXT_HIGHPOS;
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "exe_i", 1'b0);
        e.st   = 4'd6;
        e.asrc = 1'b0;
        e.regw = 1'b1;
        e.rdst = 1'b1;
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "wb_i", 1'b0);
      end
      C_LW, C_SW: begin
        e = blank(4'd7);
        e.asrc = 1'b1;
        e.ext  = EXT_SIGNED;
        e.alu  = ALUOp_ADD;
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "memadr", 1'b0);
        for (int j = 0; j <= wm; j++) begin
          mr = (j == wm);
          e = blank((cls == C_LW) ? 4'd8 : 4'd10);
          e.iord = 1'b1;
          if (cls == C_LW) e.memr = 1'b1;
          else             e.memw = 1'b1;
          cyc(e, mr, 6'($urandom), 6'($urandom), (cls == C_LW) ? "memrd" : "memwr", 1'b0);
        end
        if (cls == C_LW) begin
          e = blank(4'd9);
          e.regw = 1'b1;
          e.rdst = 1'b1;
          e.m2r  = 1'b1;
          cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "wb_mem", 1'b0);
        end
      end
      C_BR: begin
        e = blank(4'd11);
        e.alu = ALUOp_SUB;
        e.br  = (op == 6'b000101) ? 2'b10 : 2'b01;
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "br", 1'b0);
      end
      C_J: begin
        e = blank(4'd12);
        e.jmp = 1'b1;
        e.pcw = 1'b1;
        cyc(e, 1'($urandom), 6'($urandom), 6'($urandom), "jmp", 1'b0);
      end
      default: pend_ill = 1'b1;
    endcase
  endtask

  task automatic pick_instr(output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] rfn[5];
    logic [5:0] iop[7];
    logic [5:0] bad[4];
    rfn = '{6'b100001, 6'b100000, 6'b100011, 6'b100010, 6'b101010};
    iop = '{6'b001101, 6'b001010, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000101};
    bad = '{6'b111111, 6'b000001, 6'b001000, 6'b100000};
    fn = 6'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: begin op = 6'b000000; fn = rfn[$urandom_range(0, 4)]; end
      3:       begin op = 6'b000000; fn = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'b100100; end
      4:       op = 6'b000010;
      5:       op = bad[$urandom_range(0, 3)];
      default: op = iop[$urandom_range(0, 6)];
    endcase
  endtask

  initial begin
    ctl_t e;
    logic [5:0] op, fn;
    #1;
    check("reset_state", {8'h0, obs_m}, 32'h0);
    check("reset_state_nj", {8'h0, obs_n}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed instructions
    run_instr(6'b000000, 6'b100001, 0, 0);   // addu
    run_instr(6'b100011, 6'h00, 0, 2);       // lw, two stalled MEMRD cycles
    run_instr(6'b000101, 6'h00, 1, 0);       // bne after a stalled fetch
    run_instr(6'b001111, 6'h00, 0, 0);       // lui
    run_instr(6'b111111, 6'h00, 0, 0);       // illegal opcode
    run_instr(6'b000000, 6'b000000, 0, 0);   // unknown R funct
    run_instr(6'b000010, 6'h00, 0, 0);       // j
    run_instr(6'b101011, 6'h00, 0, 1);       // sw
    run_instr(6'b001101, 6'h00, 0, 0);       // ori
    run_instr(6'b001010, 6'h00, 0, 0);       // slti
    run_instr(6'b000100, 6'h00, 0, 0);       // beq

    for (int k = 0; k < 80; k++) begin
      pick_instr(op, fn);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // reset while a store is stalled in MEMWR
    run_instr(6'b000000, 6'b100000, 0, 0);
    cyc(fetch_vec(1'b1, pend_ill), 1'b1, 6'h3f, 6'h3f, "fetch_sw", 1'b0);
    pend_ill = 1'b0;
    e = blank(4'd2); e.alu = ALUOp_ADD; e.ext = EXT_SIGNED;
    cyc(e, 1'b1, 6'b101011, 6'h00, "decode_sw", 1'b0);
    e = blank(4'd7); e.asrc = 1'b1; e.ext = EXT_SIGNED; e.alu = ALUOp_ADD;
    cyc(e, 1'b1, 6'h00, 6'h00, "memadr_sw", 1'b0);
    e = blank(4'd10); e.memw = 1'b1; e.iord = 1'b1;
    cyc(e, 1'b0, 6'h00, 6'h00, "memwr_hold", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_memw", {31'h0, mw_m}, 32'h0);
    check("rst_async_all", {8'h0, obs_m}, 32'h0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held", {8'h0, obs_m}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_idle", {28'h0, st_m}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_rel_fetch", {28'h0, st_m}, 32'd1);
    run_instr(6'b000000, 6'b100011, 0, 0);   // subu after recovery

    // EN_JUMP=0 instance: j must be reported illegal
    @(negedge clk);
    rst_nj = 1'b1;
    cyc(fetch_vec(1'b1, 1'b0), 1'b1, 6'h00, 6'h00, "nj_fetch", 1'b1);
    e = blank(4'd2); e.alu = ALUOp_ADD; e.ext = EXT_SIGNED;
    cyc(e, 1'b1, 6'b000010, 6'h00, "nj_decode_j", 1'b1);
    cyc(fetch_vec(1'b1, 1'b1), 1'b1, 6'h00, 6'h00, "nj_illegal_fetch", 1'b1);
    cyc(e, 1'b1, 6'b000000, 6'b100001, "nj_decode_next", 1'b1);
    e = blank(4'd3); e.alu = ALUOp_ADDU;
    cyc(e, 1'b1, 6'h00, 6'h00, "nj_exe_r", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
